// File: rtl/ct_had_bkpt_sqc.sv
// Level-four memory-breakpoint sequencer: applies the HCR sequence condition to the
// channel A/B breakpoint hits and holds one debug request until RTU acknowledges it.
module ct_had_bkpt_sqc #(
    parameter int TMO_W   = 8,
    parameter int ARM_TMO = 0
) (
    input  logic       cpuclk,
    input  logic       cpurst,
    input  logic [2:0] regs_xx_sqc,
    input  logic       ctrl_bkpt_en,
    input  logic       bkpta_ctrl_inst_req,
    input  logic       bkpta_ctrl_data_req,
    input  logic       bkptb_ctrl_inst_req,
    input  logic       bkptb_ctrl_data_req,
    input  logic       rtu_yy_xx_dbgon,
    input  logic       rtu_had_dbg_ack,
    input  logic       x_sm_xx_update_dr_en,
    input  logic       ir_xx_hcr_reg_sel,
    output logic       sqc_ctrl_dbg_req,
    output logic       sqc_regs_armed,
    output logic [1:0] sqc_regs_cause
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        REQ   = 2'b10
    } state_e;

    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ARM_TMO);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    state_e           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [TMO_W-1:0] timer_q, timer_d;

    logic hit_a, hit_b, hcr_wr, second_hit;

    assign hit_a  = (bkpta_ctrl_inst_req | bkpta_ctrl_data_req) & ctrl_bkpt_en & ~rtu_yy_xx_dbgon;
    assign hit_b  = (bkptb_ctrl_inst_req | bkptb_ctrl_data_req) & ctrl_bkpt_en & ~rtu_yy_xx_dbgon;
    assign hcr_wr = x_sm_xx_update_dr_en & ir_xx_hcr_reg_sel;

    // The event that completes an armed A->B or B->A sequence.
    assign second_hit = ((regs_xx_sqc == 3'b011) & hit_b) | ((regs_xx_sqc == 3'b100) & hit_a);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d = state_q;
        cause_d = cause_q;
        timer_d = '0;
        case (state_q)
            IDLE: begin
                case (regs_xx_sqc)
                    3'b000: if (hit_a | hit_b) begin state_d = REQ; cause_d = {hit_b, hit_a}; end
                    3'b001: if (hit_a)         begin state_d = REQ; cause_d = 2'b01; end
                    3'b010: if (hit_b)         begin state_d = REQ; cause_d = 2'b10; end
                    3'b011: if (hit_a)         begin state_d = ARMED; timer_d = TMO_LOAD; end
                    3'b100: if (hit_b)         begin state_d = ARMED; timer_d = TMO_LOAD; end
                    3'b101: if (hit_a & hit_b) begin state_d = REQ; cause_d = 2'b11; end
                    default: ;
                endcase
            end
            ARMED: begin
                timer_d = (timer_q != '0) ? timer_q - TMO_ONE : '0;
                if (rtu_yy_xx_dbgon) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (second_hit) begin
                    state_d = REQ;
                    cause_d = 2'b11;
                    timer_d = '0;
                end else if ((ARM_TMO != 0) && (timer_q == TMO_ONE)) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            REQ: begin
                if (rtu_had_dbg_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // An HCR update restarts sequencing from a clean slate in any state.
        if (hcr_wr) begin
            state_d = IDLE;
            cause_d = 2'b00;
            timer_d = '0;
        end
    end

    always_ff @(posedge cpuclk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (cpurst) begin
            state_q <= IDLE;
            cause_q <= 2'b00;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            timer_q <= timer_d;
        end
    end

    assign sqc_ctrl_dbg_req = (state_q == REQ);
    assign sqc_regs_armed   = (state_q == ARMED);
    assign sqc_regs_cause   = cause_q;

endmodule
